// File: rtl/mips_pkg.sv
// Shared types for the hazard/forwarding controller.
// Scoreboard entries carry a fixed-width register address, zero-extended.
package mips_pkg;

  localparam int RA_MAX = 8;

  localparam logic [2:0] FWD_REGFILE = 3'd0;
  localparam logic [2:0] FWD_EX      = 3'd1;
  localparam logic [2:0] FWD_MEM     = 3'd2;

  typedef struct packed {
    logic              valid;
    logic [RA_MAX-1:0] rd;
    logic              wr;
    logic              ld;
  } sb_entry_t;

  function automatic logic src_match(
    input logic              use_src,
    input sb_entry_t         e,
    input logic [RA_MAX-1:0] src
  );
    return use_src & e.valid & e.wr & (e.rd == src) & (src != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destinations: index 0 = EX, DEPTH-1 = WB.
// A cycle without issue shifts in an invalid entry (bubble).
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  sb_entry_t             entry,
  output sb_entry_t [DEPTH-1:0] sb
);

  sb_entry_t [DEPTH-1:0] sb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q[0] <= issue ? entry : '0;
      for (int i = 1; i < DEPTH; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  assign sb = sb_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// RAW hazard detection, forwarding selects, stall/flush control
// and a saturating stall-cycle counter.
module pipeline_hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_if,
  output logic              bubble_ex,
  output logic [2:0]        fwd_a_sel,
  output logic [2:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cycles
);

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             entry;
  logic                  issue;
  logic                  raw_stall;
  logic [DEPTH-1:0]      ma;
  logic [DEPTH-1:0]      mb;
  logic [RA_MAX-1:0]     rs_x;
  logic [RA_MAX-1:0]     rt_x;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  unused_sb;

  assign rs_x = RA_MAX'(id_rs);
  assign rt_x = RA_MAX'(id_rt);

  always_comb begin
    entry.valid = 1'b1;
    entry.rd    = RA_MAX'(id_rd);
    entry.wr    = id_reg_write;
    entry.ld    = id_mem_read;
  end

  always_comb begin
    ma = '0;
    mb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ma[i] = src_match(id_use_rs, sb[i], rs_x);
      mb[i] = src_match(id_use_rt, sb[i], rt_x);
    end
  end

  // Scan oldest to youngest so the youngest producer wins; WB reads
  // through the regfile, so it is never a forwarding source.
  always_comb begin
    fwd_a_sel = FWD_REGFILE;
    fwd_b_sel = FWD_REGFILE;
    if (FWD_EN != 0) begin
      for (int i = DEPTH - 2; i >= 0; i--) begin
        if (ma[i]) fwd_a_sel = 3'(i + 1);
        if (mb[i]) fwd_b_sel = 3'(i + 1);
      end
    end
  end

  always_comb begin
    if (FWD_EN != 0) begin
      raw_stall = (ma[0] | mb[0]) & sb[0].ld;
    end else begin
      raw_stall = |(ma[DEPTH-2:0] | mb[DEPTH-2:0]);
    end
  end

  assign stall_if  = raw_stall & ~ex_branch_taken;
  assign stall_id  = raw_stall & ~ex_branch_taken;
  assign bubble_ex = raw_stall | ex_branch_taken;
  assign flush_if  = ex_branch_taken;
  assign issue     = id_valid & ~stall_id & ~ex_branch_taken;

  hazard_scoreboard #(
    .DEPTH(DEPTH)
  ) u_sb (
    .clk  (clk),
    .rst  (rst),
    .issue(issue),
    .entry(entry),
    .sb   (sb)
  );

  assign cnt_d = (stall_id && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cycles = cnt_q;
  assign unused_sb    = ^sb;

endmodule
